// File: rtl/time_set_ctrl.sv
// Front-panel edit controller: debounced mode/inc/set buttons drive a BCD HH:MM
// edit register and hold LD_time / LD_alarm long enough for a 1 Hz consumer.
module time_set_ctrl #(
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int REPEAT_CYC   = 12_500_000,
   parameter int LD_HOLD_CYC  = 55_000_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_set,
   output logic [1:0] H_in1,
   output logic [3:0] H_in0,
   output logic [3:0] M_in1,
   output logic [3:0] M_in0,
   output logic       LD_time,
   output logic       LD_alarm,
   output logic [2:0] state,
   output logic       busy
);

   localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
   localparam int RP_W = $clog2(REPEAT_CYC + 1);
   localparam int LD_W = $clog2(LD_HOLD_CYC + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      T_HR   = 3'd1,
      T_MIN  = 3'd2,
      A_HR   = 3'd3,
      A_MIN  = 3'd4,
      LOAD_T = 3'd5,
      LOAD_A = 3'd6
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        sync_p0, sync_p1, deb, deb_q, press;
   logic [DB_W-1:0]   db_cnt [3];
   logic [RP_W-1:0]   rp_cnt;
   logic [LD_W-1:0]   ld_cnt;
   logic              rep_ev, ev_mode, ev_inc, ev_set, inc_ok, ld_done, in_load;

   function automatic logic [5:0] bcd_hr_inc(input logic [1:0] t, input logic [3:0] u);
      if (t == 2'd2 && u == 4'd3) return 6'd0;
      else if (u == 4'd9)         return {t + 2'd1, 4'd0};
      else                        return {t, u + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_min_inc(input logic [3:0] t, input logic [3:0] u);
      if (u != 4'd9)        return {t, u + 4'd1};
      else if (t == 4'd5)   return 8'd0;
      else                  return {t + 4'd1, 4'd0};
   endfunction

   // Stage p0/p1: two-flop synchronizer; then per-button debounce
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
         deb     <= '0;
         deb_q   <= '0;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         sync_p0 <= {btn_set, btn_inc, btn_mode};
         sync_p1 <= sync_p0;
         deb_q   <= deb;
         for (int i = 0; i < 3; i++) begin
            if (sync_p1[i] != deb[i]) begin
               if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                  deb[i]    <= sync_p1[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   assign press = deb & ~deb_q;

   // Repeat counter sits at 0 on the press cycle and fires each time it hits REPEAT_CYC
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                         rp_cnt <= '0;
      else if (!deb[1])                     rp_cnt <= '0;
      else if (rp_cnt == RP_W'(REPEAT_CYC)) rp_cnt <= RP_W'(1);
      else                                  rp_cnt <= rp_cnt + 1'b1;
   end

   assign rep_ev  = deb[1] && (rp_cnt == RP_W'(REPEAT_CYC));
   assign ev_mode = press[0];
   assign ev_inc  = press[1] | rep_ev;
   assign ev_set  = press[2];
   assign inc_ok  = ev_inc & ~ev_mode & ~ev_set;
   assign in_load = (state_q == LOAD_T) || (state_q == LOAD_A);
   assign ld_done = (ld_cnt == LD_W'(LD_HOLD_CYC));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:           if (ev_mode) state_d = T_HR;
         T_HR:           if (ev_set) state_d = LOAD_T; else if (ev_mode) state_d = T_MIN;
         T_MIN:          if (ev_set) state_d = LOAD_T; else if (ev_mode) state_d = A_HR;
         A_HR:           if (ev_set) state_d = LOAD_A; else if (ev_mode) state_d = A_MIN;
         A_MIN:          if (ev_set) state_d = LOAD_A; else if (ev_mode) state_d = IDLE;
         LOAD_T, LOAD_A: if (ld_done) state_d = IDLE;
         default:        state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     ld_cnt <= '0;
      else if (!in_load || ld_done) ld_cnt <= '0;
      else              ld_cnt <= ld_cnt + 1'b1;
   end

   // Shared edit register: only reset clears it, loads and mode changes keep it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         {H_in1, H_in0} <= '0;
         {M_in1, M_in0} <= '0;
      end else if (inc_ok && (state_q == T_HR || state_q == A_HR)) begin
         {H_in1, H_in0} <= bcd_hr_inc(H_in1, H_in0);
      end else if (inc_ok && (state_q == T_MIN || state_q == A_MIN)) begin
         {M_in1, M_in0} <= bcd_min_inc(M_in1, M_in0);
      end
   end

   always_comb begin
      state    = state_q;
      busy     = 1'b0;
      LD_time  = 1'b0;
      LD_alarm = 1'b0;
      case (state_q)
         LOAD_T: begin busy = 1'b1; LD_time  = (ld_cnt != '0); end
         LOAD_A: begin busy = 1'b1; LD_alarm = (ld_cnt != '0); end
         default: ;
      endcase
   end

endmodule
